// File: rtl/sme_param.sv
// Streaming pattern matcher: loads a string and a pattern character by character,
// then searches for the pattern ('.', leading '^', trailing '$') and reports the first hit.
module sme_param #(
  parameter int CHAR_W    = 8,
  parameter int STR_DEPTH = 32,
  parameter int PAT_DEPTH = 8,
  parameter int IDX_W     = $clog2(STR_DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [CHAR_W-1:0] chardata,
  input  logic              isstring,
  input  logic              ispattern,
  output logic              valid,
  output logic              match,
  output logic [IDX_W-1:0]  match_index
);

  localparam int LEN_W  = $clog2(STR_DEPTH + 1);
  localparam int PLEN_W = $clog2(PAT_DEPTH + 1);
  localparam int SI_W   = $clog2(STR_DEPTH);
  localparam int PI_W   = $clog2(PAT_DEPTH);
  localparam int CW     = ((LEN_W > PLEN_W) ? LEN_W : PLEN_W) + 1;

  localparam logic [LEN_W-1:0]  STR_MAX = LEN_W'(STR_DEPTH);
  localparam logic [PLEN_W-1:0] PAT_MAX = PLEN_W'(PAT_DEPTH);
  localparam logic [CHAR_W-1:0] CH_ANY  = CHAR_W'(8'h2E);
  localparam logic [CHAR_W-1:0] CH_BOL  = CHAR_W'(8'h5E);
  localparam logic [CHAR_W-1:0] CH_EOL  = CHAR_W'(8'h24);

  typedef enum logic [2:0] {IDLE, LOAD_STR, LOAD_PAT, SEARCH, DONE} state_t;

  state_t              state, state_n;
  logic [LEN_W-1:0]    str_len, str_len_n;
  logic [PLEN_W-1:0]   pat_len, pat_len_n;
  logic [CW-1:0]       s_pos, s_pos_n;
  logic [PLEN_W-1:0]   k_pos, k_pos_n;
  logic                isstring_d, ispattern_d;
  logic                valid_n, match_n;
  logic [IDX_W-1:0]    match_index_n;

  logic [CHAR_W-1:0]   str_mem [STR_DEPTH];
  logic [CHAR_W-1:0]   pat_mem [PAT_DEPTH];
  logic                str_we, pat_we;
  logic [SI_W-1:0]     str_wa;
  logic [PI_W-1:0]     pat_wa;

  logic                str_rise, pat_rise;
  logic                bol, eol, char_ok;
  logic [PLEN_W-1:0]   eff_len;
  logic [CW-1:0]       str_c, eff_c, span, s_hi;
  logic [SI_W-1:0]     str_ra;
  logic [PI_W-1:0]     pat_ra;
  logic [CHAR_W-1:0]   pat_ch;

  // Anchors only count in their own positions; everything else is a literal
  always_comb begin
    bol     = (pat_len != '0) && (pat_mem[0] == CH_BOL);
    eol     = (pat_len != '0) && (pat_mem[PI_W'(pat_len - PLEN_W'(1))] == CH_EOL);
    eff_len = pat_len - PLEN_W'(bol) - PLEN_W'(eol);
    str_c   = CW'(str_len);
    eff_c   = CW'(eff_len);
    span    = str_c - eff_c;
    s_hi    = bol ? '0 : span;
    str_ra  = SI_W'(s_pos + CW'(k_pos));
    pat_ra  = PI_W'(CW'(k_pos) + CW'(bol));
    pat_ch  = pat_mem[pat_ra];
    char_ok = (pat_ch == CH_ANY) || (pat_ch == str_mem[str_ra]);
  end

  assign str_rise = isstring & ~isstring_d;
  assign pat_rise = ispattern & ~ispattern_d & ~isstring;

  always_comb begin
    state_n       = state;
    str_len_n     = str_len;
    pat_len_n     = pat_len;
    s_pos_n       = s_pos;
    k_pos_n       = k_pos;
    valid_n       = 1'b0;
    match_n       = 1'b0;
    match_index_n = '0;
    str_we        = 1'b0;
    pat_we        = 1'b0;
    str_wa        = SI_W'(str_len);
    pat_wa        = PI_W'(pat_len);

    if (str_rise) begin
      state_n   = LOAD_STR;
      str_len_n = LEN_W'(1);
      str_we    = 1'b1;
      str_wa    = '0;
    end else if (pat_rise) begin
      state_n   = LOAD_PAT;
      pat_len_n = PLEN_W'(1);
      pat_we    = 1'b1;
      pat_wa    = '0;
    end else begin
      case (state)
        LOAD_STR: begin
          if (!isstring) begin
            state_n = IDLE;
          end else if (str_len != STR_MAX) begin
            str_we    = 1'b1;
            str_len_n = str_len + LEN_W'(1);
          end
        end
        LOAD_PAT: begin
          if (!ispattern) begin
            // An end-anchored search can only succeed at one start position
            state_n = SEARCH;
            s_pos_n = (eol && (eff_c <= str_c)) ? span : '0;
            k_pos_n = '0;
          end else if (pat_len != PAT_MAX) begin
            pat_we    = 1'b1;
            pat_len_n = pat_len + PLEN_W'(1);
          end
        end
        SEARCH: begin
          if (eff_len == '0) begin
            state_n = DONE;
            valid_n = 1'b1;
            match_n = 1'b1;
          end else if ((eff_c > str_c) || (s_pos > s_hi)) begin
            state_n = DONE;
            valid_n = 1'b1;
          end else if (char_ok) begin
            if (k_pos == eff_len - PLEN_W'(1)) begin
              state_n       = DONE;
              valid_n       = 1'b1;
              match_n       = 1'b1;
              match_index_n = IDX_W'(s_pos);
            end else begin
              k_pos_n = k_pos + PLEN_W'(1);
            end
          end else begin
            s_pos_n = s_pos + CW'(1);
            k_pos_n = '0;
          end
        end
        DONE:    state_n = IDLE;
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      str_len     <= '0;
      pat_len     <= '0;
      s_pos       <= '0;
      k_pos       <= '0;
      isstring_d  <= 1'b0;
      ispattern_d <= 1'b0;
      valid       <= 1'b0;
      match       <= 1'b0;
      match_index <= '0;
    end else begin
      state       <= state_n;
      str_len     <= str_len_n;
      pat_len     <= pat_len_n;
      s_pos       <= s_pos_n;
      k_pos       <= k_pos_n;
      isstring_d  <= isstring;
      ispattern_d <= ispattern;
      valid       <= valid_n;
      match       <= match_n;
      match_index <= match_index_n;
    end
  end

  // Character storage is never cleared; the length registers define what is live
  always_ff @(posedge clk) begin
    if (!reset && str_we) str_mem[str_wa] <= chardata;
    if (!reset && pat_we) pat_mem[pat_wa] <= chardata;
  end

endmodule

// File: tb/tb_sme_param.sv
// Bench for sme_param: directed string/pattern loads checked against a
// string-level reference model, with literal pins on the model's answers.
module tb_sme_param;

  localparam int STR_DEPTH = 32;
  localparam int PAT_DEPTH = 8;
  localparam int BOUND     = STR_DEPTH * PAT_DEPTH + 4;

  logic       clk = 1'b0;
  logic       reset, isstring, ispattern;
  logic [7:0] chardata;
  logic       valid, match;
  logic [4:0] match_index;

  sme_param #(.CHAR_W(8), .STR_DEPTH(STR_DEPTH), .PAT_DEPTH(PAT_DEPTH), .IDX_W(5)) dut (
    .clk(clk), .reset(reset), .chardata(chardata), .isstring(isstring),
    .ispattern(ispattern), .valid(valid), .match(match), .match_index(match_index)
  );

  always #5 clk = ~clk;

  int         checks = 0, errors = 0;
  int         exp_cnt = 0, done_cnt = 0, wait_cyc = 0;
  bit         armed = 1'b0;
  logic       exp_match, lit_match, has_lit;
  logic [4:0] exp_idx, lit_idx;
  string      cur_str = "", cur_pat = "";

  // Reference: first start position where the pattern body fits, honouring anchors
  function automatic int model(input string s, input string p);
    int slen, plen, lo, n;
    bit bol, eol, ok;
    slen = (s.len() > STR_DEPTH) ? STR_DEPTH : s.len();
    plen = (p.len() > PAT_DEPTH) ? PAT_DEPTH : p.len();
    bol  = (plen > 0) && (p[0] == 8'h5E);
    eol  = (plen > 0) && (p[plen-1] == 8'h24);
    lo   = bol ? 1 : 0;
    n    = plen - lo - (eol ? 1 : 0);
    if (n == 0) return 0;
    for (int st = 0; st + n <= slen; st++) begin
      ok = 1'b1;
      if (bol && st != 0) ok = 1'b0;
      if (eol && st + n != slen) ok = 1'b0;
      for (int j = 0; j < n; j++)
        if (p[lo+j] != 8'h2E && p[lo+j] != s[st+j]) ok = 1'b0;
      if (ok) return st;
    end
    return -1;
  endfunction

  always @(negedge clk) begin
    if (armed) begin
      if (done_cnt < exp_cnt) wait_cyc++;
      else wait_cyc = 0;
      if (valid === 1'b1) begin
        checks++;
        if (done_cnt >= exp_cnt) begin
          errors++;
          $display("FAIL unexpected_valid: got valid=1 match=%0d idx=%0d, required valid=0",
                   match, match_index);
        end else begin
          if (match !== exp_match || match_index !== exp_idx) begin
            errors++;
            $display("FAIL result[%s|%s]: got match=%0d idx=%0d, required match=%0d idx=%0d",
                     cur_str, cur_pat, match, match_index, exp_match, exp_idx);
          end
          if (has_lit) begin
            checks++;
            if (exp_match !== lit_match || exp_idx !== lit_idx) begin
              errors++;
              $display("FAIL model_pin[%s|%s]: model match=%0d idx=%0d, hand value match=%0d idx=%0d",
                       cur_str, cur_pat, exp_match, exp_idx, lit_match, lit_idx);
            end
          end
          done_cnt++;
          wait_cyc = 0;
        end
      end else begin
        checks++;
        if (valid !== 1'b0 || match !== 1'b0 || match_index !== 5'd0) begin
          errors++;
          $display("FAIL idle_outputs: got valid=%0d match=%0d idx=%0d, required all 0",
                   valid, match, match_index);
        end
        if (wait_cyc > BOUND) begin
          checks++;
          errors++;
          $display("FAIL timeout[%s|%s]: no valid after %0d cycles, required within %0d",
                   cur_str, cur_pat, wait_cyc, BOUND);
          done_cnt++;
          wait_cyc = 0;
        end
      end
    end
  end

  task automatic load_str(input string s);
    for (int i = 0; i < s.len(); i++) begin
      chardata = s[i];
      isstring = 1'b1;
      @(posedge clk); #1;
    end
    isstring = 1'b0;
    chardata = 8'h00;
    cur_str  = s;
    @(posedge clk); #1;
  endtask

  task automatic load_pat(input string p, input bit want, input bit lit,
                          input logic lm, input int li);
    int r;
    for (int i = 0; i < p.len(); i++) begin
      chardata  = p[i];
      ispattern = 1'b1;
      @(posedge clk); #1;
    end
    ispattern = 1'b0;
    chardata  = 8'h00;
    if (want) begin
      r         = model(cur_str, p);
      exp_match = (r >= 0);
      exp_idx   = (r >= 0) ? 5'(r) : 5'd0;
      has_lit   = lit;
      lit_match = lm;
      lit_idx   = 5'(li);
      cur_pat   = p;
      exp_cnt++;
    end
  endtask

  task automatic wait_done();
    for (int n = 0; n < 2 * BOUND && done_cnt < exp_cnt; n++) @(negedge clk);
    if (done_cnt < exp_cnt) begin
      $display("FAIL wait_done: result never consumed for pattern %s", cur_pat);
      $fatal(1, "bench stalled");
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic run_pat(input string p, input logic lm, input int li);
    load_pat(p, 1'b1, 1'b1, lm, li);
    wait_done();
  endtask

  initial begin
    reset = 1'b1; isstring = 1'b0; ispattern = 1'b0; chardata = 8'h00;
    @(posedge clk); #1;
    armed = 1'b1;
    repeat (2) @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    // Empty string after reset
    run_pat("a", 1'b0, 0);
    run_pat("^$", 1'b1, 0);

    load_str("abcabd");
    run_pat("abd", 1'b1, 3);
    run_pat("^bc", 1'b0, 0);
    run_pat("a.d$", 1'b1, 3);
    run_pat("c", 1'b1, 2);
    run_pat("b^", 1'b0, 0);
    run_pat("$", 1'b1, 0);
    run_pat("^ab", 1'b1, 0);
    run_pat("bd$", 1'b1, 4);
    run_pat("abcabd", 1'b1, 0);
    run_pat("abcabdx", 1'b0, 0);

    load_str("abcd");
    run_pat("abcdefghij", 1'b0, 0);

    load_str("abcdefghijklmnoprstuvwxyzabcdefqzzzzzzzz");
    run_pat("q$", 1'b1, 31);
    run_pat("z", 1'b1, 24);
    run_pat("qz", 1'b0, 0);

    // Pattern restarted three cycles into the search
    load_str("abcabd");
    load_pat("abd", 1'b0, 1'b0, 1'b0, 0);
    repeat (3) @(posedge clk); #1;
    run_pat("bc", 1'b1, 1);

    // Reset during a search clears the string and yields no result
    load_pat("abd", 1'b0, 1'b0, 1'b0, 0);
    repeat (2) @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    cur_str = "";
    repeat (20) @(posedge clk); #1;
    run_pat("a", 1'b0, 0);
    load_str("abcabd");
    run_pat("abd", 1'b1, 3);

    // Simultaneous strobes: the string load wins
    for (int i = 0; i < 2; i++) begin
      chardata  = (i == 0) ? 8'h78 : 8'h79;
      isstring  = 1'b1;
      ispattern = 1'b1;
      @(posedge clk); #1;
    end
    isstring = 1'b0; ispattern = 1'b0; chardata = 8'h00;
    cur_str = "xy";
    repeat (2) @(posedge clk); #1;
    run_pat("y", 1'b1, 1);

    repeat (4) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sme_param.md
SME_PARAM -- requirements
Module: sme_param

Interface
REQ-001 SHALL have parameter CHAR_W, default 8, character width in bits.
REQ-002 SHALL have parameter STR_DEPTH, default 32, maximum stored string length in characters.
REQ-003 SHALL have parameter PAT_DEPTH, default 8, maximum stored pattern length in characters, including anchors.
REQ-004 SHALL have parameter IDX_W, default $clog2(STR_DEPTH), match_index width.
REQ-005 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-006 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-007 SHALL have port chardata  input  CHAR_W  character sampled while isstring or ispattern is high.
REQ-008 SHALL have port isstring  input  1  string character strobe.
REQ-009 SHALL have port ispattern  input  1  pattern character strobe.
REQ-010 SHALL have port valid  output  1  one-cycle result strobe.
REQ-011 SHALL have port match  output  1  result: pattern found.
REQ-012 SHALL have port match_index  output  IDX_W  string index of the first matched character.

Function
REQ-013 SHALL implement states IDLE, LOAD_STR, LOAD_PAT, SEARCH and DONE.
REQ-014 SHALL, on a rising isstring (low in the previous cycle), clear the stored string and enter LOAD_STR; each isstring-high cycle stores chardata at the next index; str_len saturates at STR_DEPTH and excess characters are dropped.
REQ-015 SHALL, on a rising ispattern, clear the stored pattern and enter LOAD_PAT, loading like REQ-014 with saturation at PAT_DEPTH; the stored string is kept, so several patterns can run against one string.
REQ-016 SHALL, when isstring and ispattern are high in the same cycle, take isstring and ignore ispattern.
REQ-017 SHALL enter SEARCH in the cycle after ispattern falls; falling isstring returns to IDLE.
REQ-018 SHALL treat 8'h2E ('.') in any pattern position as matching any string character.
REQ-019 SHALL treat 8'h5E ('^') in pattern position 0 as a start anchor: match allowed only at string index 0; the '^' is excluded from comparison.
REQ-020 SHALL treat 8'h24 ('$') in the last pattern position as an end anchor: the match must end at index str_len-1; the '$' is excluded from comparison.
REQ-021 SHALL treat '^' and '$' in any other position as literal characters.
REQ-022 SHALL, in SEARCH, test start positions s = 0 .. str_len-eff_len in ascending order (eff_len = pattern length minus anchors), one character comparison per clock, abandoning a start position on the first mismatch.
REQ-023 SHALL report the lowest matching s.
REQ-024 SHALL reach DONE within STR_DEPTH*PAT_DEPTH+2 cycles of entering SEARCH.
REQ-025 SHALL, in DONE, assert valid for exactly one cycle, then return to IDLE.
REQ-026 SHALL, on a match, drive match=1 and match_index=s with valid.
REQ-027 SHALL, on no match, drive match=0 and match_index=0 with valid.
REQ-028 SHALL drive match=0 and match_index=0 whenever valid=0.
REQ-029 SHALL give no match (match=0, valid pulsed) when eff_len > str_len or str_len = 0, except that eff_len = 0 gives match=1, match_index=0.
REQ-030 SHALL, when isstring or ispattern rises during SEARCH, abort the search without a valid pulse and begin the corresponding load that cycle.
REQ-031 SHALL register all outputs, with no combinational path from inputs to outputs.

Reset
REQ-032 SHALL, with reset high at a rising clk edge, force state=IDLE, str_len=0, pat_len=0, valid=0, match=0 and match_index=0 from the next cycle.
REQ-033 SHALL let reset override all other inputs, including mid-load and mid-SEARCH, and SHALL NOT produce a valid pulse for an aborted search.
REQ-034 SHALL NOT require the string or pattern storage arrays to be reset.

Verification
REQ-035 SHALL cover: string "abcabd", pattern "abd" -> single valid, match=1, match_index=3.
REQ-036 SHALL cover: same string, pattern "^bc" -> match=0, match_index=0; then pattern "a.d$" with no string reload -> match=1, match_index=3.
REQ-037 SHALL cover: 40-character string (index 31 = 'q', no other 'q'), pattern "q$" -> str_len saturates at 32, match=1, match_index=31.
REQ-038 SHALL cover: 10-character pattern with PAT_DEPTH=8 against a 4-character string -> match=0.
REQ-039 SHALL cover: ispattern re-asserted three cycles into SEARCH -> no valid for the first pattern; exactly one valid for the second, with the correct result.
REQ-040 SHALL cover: reset pulsed mid-SEARCH -> valid, match and match_index all 0 from the next cycle, with no valid pulse until a new pattern completes.
